// File: rtl/axi_slave_read_data_if.sv
// AXI4 read-address and read-data channel bundle for the slave read engine.
// The master modport drives requests and rready; the slave modport answers.
interface axi_slave_read_data_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_slave_read_data.sv
// AXI4 slave read engine: accepts one AR burst, walks FIXED/INCR/WRAP addresses
// and streams words from a local backdoor-loaded memory onto the R channel.
// Illegal bursts still produce every beat, but with SLVERR and zero data.
module axi_slave_read_data #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int MEM_WORDS = 16384
) (
  input  logic              aclk,
  input  logic              areset,
  axi_slave_read_data_if.slave bus,
  input  logic              mem_we,
  input  logic [ADDR_W-3:0] mem_waddr,
  input  logic [DATA_W-1:0] mem_wdata
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_DATA = 1'b1} state_t;

  // Bursts we refuse: reserved type, beats wider than the bus, odd WRAP lengths.
  function automatic logic burst_err_f(input logic [1:0] burst,
                                       input logic [2:0] size,
                                       input logic [7:0] len);
    logic bad_wrap_len;
    bad_wrap_len = !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
    burst_err_f  = (burst == 2'b11) || (size > 3'd2) || ((burst == 2'b10) && bad_wrap_len);
  endfunction

  logic [DATA_W-1:0] mem_r [MEM_WORDS];

  state_t            state_r, state_nx_s;
  logic [ADDR_W-1:0] addr_r, addr_nx_s;
  logic [7:0]        len_r, len_nx_s;
  logic [2:0]        size_r, size_nx_s;
  logic [1:0]        burst_r, burst_nx_s;
  logic [7:0]        cnt_r, cnt_nx_s;
  logic              err_r, err_nx_s;
  logic [ADDR_W:0]   total_r, total_nx_s;
  logic [ADDR_W-1:0] wrap_bnd_r, wrap_bnd_nx_s;
  logic [DATA_W-1:0] rdata_r, rdata_nx_s;
  logic [1:0]        rresp_r, rresp_nx_s;
  logic              rlast_r, rlast_nx_s;
  logic              rvalid_r, rvalid_nx_s;

  // One extra bit on the address sums so a WRAP window ending at 2^ADDR_W compares correctly.
  logic [ADDR_W:0]   step_s, sum_s, lim_s;
  logic [ADDR_W-1:0] adv_addr_s;
  logic [ADDR_W:0]   cap_total_s;
  logic [ADDR_W-1:0] cap_bnd_s;
  logic              cap_err_s;
  logic [ADDR_W-1:0] fetch_addr_s;
  logic [DATA_W-1:0] mem_rd_s;

  assign bus.arready = (state_r == ST_IDLE);
  assign bus.rdata   = rdata_r;
  assign bus.rresp   = rresp_r;
  assign bus.rlast   = rlast_r;
  assign bus.rvalid  = rvalid_r;

  // Backdoor preload port; a fetch on the same edge still sees the old word.
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      mem_r[mem_waddr] <= mem_wdata;
    end
  end

  // Burst geometry of the incoming AR request.
  always_comb begin
    cap_total_s = ({{(ADDR_W-7){1'b0}}, bus.arlen} + {{ADDR_W{1'b0}}, 1'b1}) << bus.arsize;
    cap_bnd_s   = bus.araddr & ~(cap_total_s[ADDR_W-1:0] - {{(ADDR_W-1){1'b0}}, 1'b1});
    cap_err_s   = burst_err_f(bus.arburst, bus.arsize, bus.arlen);
  end

  // Address of the beat following the current one.
  always_comb begin
    step_s = {{ADDR_W{1'b0}}, 1'b1} << size_r;
    sum_s  = {1'b0, addr_r} + step_s;
    lim_s  = {1'b0, wrap_bnd_r} + total_r;
    case (burst_r)
      2'b00:   adv_addr_s = addr_r;
      2'b01:   adv_addr_s = sum_s[ADDR_W-1:0];
      2'b10: begin
        if (sum_s >= lim_s) begin
          adv_addr_s = wrap_bnd_r;
        end else begin
          adv_addr_s = sum_s[ADDR_W-1:0];
        end
      end
      default: adv_addr_s = addr_r;
    endcase
  end

  // Word to load into rdata: the request address when idle, else the next beat address.
  always_comb begin
    if (state_r == ST_IDLE) begin
      fetch_addr_s = bus.araddr;
    end else begin
      fetch_addr_s = adv_addr_s;
    end
    mem_rd_s = mem_r[fetch_addr_s[ADDR_W-1:2]];
  end

  // Next-state and next-output logic for the burst FSM.
  always_comb begin
    state_nx_s    = state_r;
    addr_nx_s     = addr_r;
    len_nx_s      = len_r;
    size_nx_s     = size_r;
    burst_nx_s    = burst_r;
    cnt_nx_s      = cnt_r;
    err_nx_s      = err_r;
    total_nx_s    = total_r;
    wrap_bnd_nx_s = wrap_bnd_r;
    rdata_nx_s    = rdata_r;
    rresp_nx_s    = rresp_r;
    rlast_nx_s    = rlast_r;
    rvalid_nx_s   = rvalid_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.arvalid) begin
          state_nx_s    = ST_DATA;
          addr_nx_s     = bus.araddr;
          len_nx_s      = bus.arlen;
          size_nx_s     = bus.arsize;
          burst_nx_s    = bus.arburst;
          cnt_nx_s      = 8'd0;
          err_nx_s      = cap_err_s;
          total_nx_s    = cap_total_s;
          wrap_bnd_nx_s = cap_bnd_s;
          rvalid_nx_s   = 1'b1;
          rlast_nx_s    = (bus.arlen == 8'd0);
          rresp_nx_s    = cap_err_s ? 2'b10 : 2'b00;
          rdata_nx_s    = cap_err_s ? {DATA_W{1'b0}} : mem_rd_s;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (bus.rready) begin
          if (rlast_r) begin
            state_nx_s  = ST_IDLE;
            rvalid_nx_s = 1'b0;
            rlast_nx_s  = 1'b0;
          end else begin
            cnt_nx_s   = cnt_r + 8'd1;
            addr_nx_s  = adv_addr_s;
            rlast_nx_s = ((cnt_r + 8'd1) == len_r);
            rdata_nx_s = err_r ? {DATA_W{1'b0}} : mem_rd_s;
          end
        end else begin
          state_nx_s = ST_DATA;
        end
      end
      default: begin
        state_nx_s  = ST_IDLE;
        rvalid_nx_s = 1'b0;
        rlast_nx_s  = 1'b0;
      end
    endcase
  end

  // Burst state and R-channel output registers; reset abandons any burst.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_r    <= ST_IDLE;
      addr_r     <= {ADDR_W{1'b0}};
      len_r      <= 8'd0;
      size_r     <= 3'd0;
      burst_r    <= 2'b00;
      cnt_r      <= 8'd0;
      err_r      <= 1'b0;
      total_r    <= {(ADDR_W+1){1'b0}};
      wrap_bnd_r <= {ADDR_W{1'b0}};
      rdata_r    <= {DATA_W{1'b0}};
      rresp_r    <= 2'b00;
      rlast_r    <= 1'b0;
      rvalid_r   <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      addr_r     <= addr_nx_s;
      len_r      <= len_nx_s;
      size_r     <= size_nx_s;
      burst_r    <= burst_nx_s;
      cnt_r      <= cnt_nx_s;
      err_r      <= err_nx_s;
      total_r    <= total_nx_s;
      wrap_bnd_r <= wrap_bnd_nx_s;
      rdata_r    <= rdata_nx_s;
      rresp_r    <= rresp_nx_s;
      rlast_r    <= rlast_nx_s;
      rvalid_r   <= rvalid_nx_s;
    end
  end

endmodule

// File: tb/tb_axi_slave_read_data.sv
// Directed bench for axi_slave_read_data: burst types, stalls, error bursts,
// narrow/address-wrap cases, reset mid-burst and backdoor write collisions.
module tb_axi_slave_read_data;

  logic        aclk;
  logic        areset;
  logic        mem_we;
  logic [13:0] mem_waddr;
  logic [31:0] mem_wdata;
  int          total;
  int          bad;

  axi_slave_read_data_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  axi_slave_read_data #(.ADDR_W(16), .DATA_W(32), .MEM_WORDS(16384)) dut (
    .aclk      (aclk),
    .areset    (areset),
    .bus       (bus),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata)
  );

  // Free-running clock, rising edge at 5, 15, 25 ...
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, want finished", $time);
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic send_ar(input logic [15:0] a, input logic [7:0] l,
                         input logic [2:0] s, input logic [1:0] b);
    bus.araddr  = a;
    bus.arlen   = l;
    bus.arsize  = s;
    bus.arburst = b;
    bus.arvalid = 1'b1;
    tick();
    bus.arvalid = 1'b0;
  endtask

  task automatic preload(input logic [13:0] idx, input logic [31:0] val);
    mem_we    = 1'b1;
    mem_waddr = idx;
    mem_wdata = val;
    tick();
    mem_we    = 1'b0;
  endtask

  task automatic test_reset;
    total++;
    if (bus.rvalid !== 1'b0 || bus.rlast !== 1'b0 || bus.rdata !== 32'h0 ||
        bus.rresp !== 2'b00 || bus.arready !== 1'b1) begin
      bad++;
      $display("FAIL reset: got v=%b l=%b d=%h r=%b ar=%b, want v=0 l=0 d=0 r=00 ar=1",
               bus.rvalid, bus.rlast, bus.rdata, bus.rresp, bus.arready);
    end
  endtask

  task automatic test_incr;
    logic [31:0] exp_d;
    bus.rready = 1'b1;
    send_ar(16'h0010, 8'd3, 3'd2, 2'b01);
    for (int i = 0; i < 4; i++) begin
      exp_d = 32'hA4 + i;
      total++;
      if (bus.rvalid !== 1'b1 || bus.rdata !== exp_d || bus.rlast !== (i == 3) ||
          bus.rresp !== 2'b00) begin
        bad++;
        $display("FAIL incr_beat%0d: got v=%b d=%h l=%b r=%b, want v=1 d=%h l=%b r=00",
                 i, bus.rvalid, bus.rdata, bus.rlast, bus.rresp, exp_d, (i == 3));
      end
      tick();
    end
    total++;
    if (bus.rvalid !== 1'b0 || bus.rlast !== 1'b0 || bus.arready !== 1'b1) begin
      bad++;
      $display("FAIL incr_end: got v=%b l=%b ar=%b, want v=0 l=0 ar=1",
               bus.rvalid, bus.rlast, bus.arready);
    end
  endtask

  task automatic test_wrap;
    logic [31:0] exp_d [4];
    exp_d = '{32'hA6, 32'hA7, 32'hA4, 32'hA5};
    bus.rready = 1'b1;
    send_ar(16'h0018, 8'd3, 3'd2, 2'b10);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (bus.rvalid !== 1'b1 || bus.rdata !== exp_d[i] || bus.rlast !== (i == 3) ||
          bus.rresp !== 2'b00) begin
        bad++;
        $display("FAIL wrap_beat%0d: got v=%b d=%h l=%b r=%b, want v=1 d=%h l=%b r=00",
                 i, bus.rvalid, bus.rdata, bus.rlast, bus.rresp, exp_d[i], (i == 3));
      end
      tick();
    end
    total++;
    if (bus.rvalid !== 1'b0 || bus.arready !== 1'b1) begin
      bad++;
      $display("FAIL wrap_end: got v=%b ar=%b, want v=0 ar=1", bus.rvalid, bus.arready);
    end
  endtask

  task automatic test_fixed_stall;
    bus.rready = 1'b1;
    send_ar(16'h0008, 8'd2, 3'd2, 2'b00);
    for (int b = 0; b < 3; b++) begin
      total++;
      if (bus.rvalid !== 1'b1 || bus.rdata !== 32'hA2 || bus.rlast !== (b == 2) ||
          bus.arready !== 1'b0) begin
        bad++;
        $display("FAIL fixed_beat%0d: got v=%b d=%h l=%b ar=%b, want v=1 d=000000a2 l=%b ar=0",
                 b, bus.rvalid, bus.rdata, bus.rlast, bus.arready, (b == 2));
      end
      bus.rready = 1'b0;
      tick();
      total++;
      if (bus.rvalid !== 1'b1 || bus.rdata !== 32'hA2 || bus.rlast !== (b == 2) ||
          bus.arready !== 1'b0) begin
        bad++;
        $display("FAIL fixed_stall%0d: got v=%b d=%h l=%b ar=%b, want v=1 d=000000a2 l=%b ar=0",
                 b, bus.rvalid, bus.rdata, bus.rlast, bus.arready, (b == 2));
      end
      bus.rready = 1'b1;
      tick();
    end
    total++;
    if (bus.rvalid !== 1'b0 || bus.arready !== 1'b1) begin
      bad++;
      $display("FAIL fixed_end: got v=%b ar=%b, want v=0 ar=1", bus.rvalid, bus.arready);
    end
  endtask

  task automatic test_error;
    bus.rready = 1'b1;
    send_ar(16'h0010, 8'd1, 3'd2, 2'b11);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h0 || bus.rlast !== (i == 1) ||
          bus.rresp !== 2'b10) begin
        bad++;
        $display("FAIL err_rsvd_beat%0d: got v=%b d=%h l=%b r=%b, want v=1 d=0 l=%b r=10",
                 i, bus.rvalid, bus.rdata, bus.rlast, bus.rresp, (i == 1));
      end
      tick();
    end
    send_ar(16'h0010, 8'd2, 3'd2, 2'b10);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h0 || bus.rlast !== (i == 2) ||
          bus.rresp !== 2'b10) begin
        bad++;
        $display("FAIL err_wrap_beat%0d: got v=%b d=%h l=%b r=%b, want v=1 d=0 l=%b r=10",
                 i, bus.rvalid, bus.rdata, bus.rlast, bus.rresp, (i == 2));
      end
      tick();
    end
    total++;
    if (bus.rvalid !== 1'b0 || bus.arready !== 1'b1) begin
      bad++;
      $display("FAIL err_end: got v=%b ar=%b, want v=0 ar=1", bus.rvalid, bus.arready);
    end
  endtask

  task automatic test_narrow_and_addr_wrap;
    logic [31:0] exp_n [5];
    logic [31:0] exp_w [2];
    exp_n = '{32'hA0, 32'hA0, 32'hA0, 32'hA1, 32'hA1};
    exp_w = '{32'hC0FFEE01, 32'hA0};
    bus.rready = 1'b1;
    send_ar(16'h0001, 8'd4, 3'd0, 2'b01);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (bus.rvalid !== 1'b1 || bus.rdata !== exp_n[i] || bus.rlast !== (i == 4) ||
          bus.rresp !== 2'b00) begin
        bad++;
        $display("FAIL narrow_beat%0d: got v=%b d=%h l=%b r=%b, want v=1 d=%h l=%b r=00",
                 i, bus.rvalid, bus.rdata, bus.rlast, bus.rresp, exp_n[i], (i == 4));
      end
      tick();
    end
    send_ar(16'hFFFC, 8'd1, 3'd2, 2'b01);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (bus.rvalid !== 1'b1 || bus.rdata !== exp_w[i] || bus.rlast !== (i == 1)) begin
        bad++;
        $display("FAIL addrwrap_beat%0d: got v=%b d=%h l=%b, want v=1 d=%h l=%b",
                 i, bus.rvalid, bus.rdata, bus.rlast, exp_w[i], (i == 1));
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_burst;
    bus.rready = 1'b1;
    send_ar(16'h0000, 8'd7, 3'd2, 2'b01);
    tick();
    tick();
    total++;
    if (bus.rvalid !== 1'b1 || bus.rdata !== 32'hA2 || bus.rlast !== 1'b0) begin
      bad++;
      $display("FAIL midrst_beat3: got v=%b d=%h l=%b, want v=1 d=000000a2 l=0",
               bus.rvalid, bus.rdata, bus.rlast);
    end
    areset = 1'b1;
    tick();
    areset = 1'b0;
    total++;
    if (bus.rvalid !== 1'b0 || bus.rlast !== 1'b0 || bus.arready !== 1'b1) begin
      bad++;
      $display("FAIL midrst_after: got v=%b l=%b ar=%b, want v=0 l=0 ar=1",
               bus.rvalid, bus.rlast, bus.arready);
    end
    send_ar(16'h0004, 8'd1, 3'd2, 2'b01);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (bus.rvalid !== 1'b1 || bus.rdata !== (32'hA1 + i) || bus.rlast !== (i == 1) ||
          bus.rresp !== 2'b00) begin
        bad++;
        $display("FAIL midrst_next_beat%0d: got v=%b d=%h l=%b r=%b, want v=1 d=%h l=%b r=00",
                 i, bus.rvalid, bus.rdata, bus.rlast, bus.rresp, 32'hA1 + i, (i == 1));
      end
      tick();
    end
  endtask

  task automatic test_backdoor_collision;
    bus.rready = 1'b0;
    send_ar(16'h001C, 8'd1, 3'd2, 2'b01);
    total++;
    if (bus.rvalid !== 1'b1 || bus.rdata !== 32'hA7) begin
      bad++;
      $display("FAIL coll_beat0: got v=%b d=%h, want v=1 d=000000a7", bus.rvalid, bus.rdata);
    end
    bus.rready = 1'b1;
    mem_we     = 1'b1;
    mem_waddr  = 14'd8;
    mem_wdata  = 32'h22;
    tick();
    mem_we = 1'b0;
    total++;
    if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h11 || bus.rlast !== 1'b1) begin
      bad++;
      $display("FAIL coll_old: got v=%b d=%h l=%b, want v=1 d=00000011 l=1",
               bus.rvalid, bus.rdata, bus.rlast);
    end
    tick();
    send_ar(16'h0020, 8'd0, 3'd2, 2'b00);
    total++;
    if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h22 || bus.rlast !== 1'b1) begin
      bad++;
      $display("FAIL coll_new: got v=%b d=%h l=%b, want v=1 d=00000022 l=1",
               bus.rvalid, bus.rdata, bus.rlast);
    end
    tick();
    total++;
    if (bus.rvalid !== 1'b0 || bus.arready !== 1'b1) begin
      bad++;
      $display("FAIL coll_end: got v=%b ar=%b, want v=0 ar=1", bus.rvalid, bus.arready);
    end
  endtask

  // Test sequence: reset with memory preload, then each scenario in turn.
  initial begin
    total       = 0;
    bad         = 0;
    areset      = 1'b1;
    mem_we      = 1'b0;
    mem_waddr   = 14'd0;
    mem_wdata   = 32'd0;
    bus.araddr  = 16'h0;
    bus.arlen   = 8'd0;
    bus.arsize  = 3'd0;
    bus.arburst = 2'b00;
    bus.arvalid = 1'b0;
    bus.rready  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      preload(14'(i), 32'hA0 + i);
    end
    preload(14'd8, 32'h11);
    preload(14'h3FFF, 32'hC0FFEE01);
    tick();
    areset = 1'b0;
    tick();
    test_reset();
    test_incr();
    test_wrap();
    test_fixed_stall();
    test_error();
    test_narrow_and_addr_wrap();
    test_reset_mid_burst();
    test_backdoor_collision();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
